// File: rtl/sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_client_arbiter
// Purpose  : Arbitrates N frame-engine clients onto one SDRAM controller port.
//            One real-time client has absolute priority; the others share the
//            bus round-robin with burst locking and a per-grant word limit.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_client_arbiter #(
  parameter  int NUM_CLIENTS = 4,
  parameter  int ADDR_W      = 22,
  parameter  int DATA_W      = 128,
  parameter  int RT_ID       = 0,
  parameter  int MAX_BURST   = 16,
  localparam int BE_W        = DATA_W / 8,
  localparam int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rt_window,
  input  logic [NUM_CLIENTS-1:0]        cli_rd,
  input  logic [NUM_CLIENTS-1:0]        cli_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wrdata,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cli_be,
  output logic [NUM_CLIENTS-1:0]        cli_ac,
  output logic [NUM_CLIENTS-1:0]        cli_wait,
  output logic [DATA_W-1:0]             cli_rddata,
  output logic [ADDR_W-1:0]             ar_addr,
  output logic [BE_W-1:0]               ar_be,
  output logic                          ar_read,
  output logic                          ar_write,
  output logic [DATA_W-1:0]             ar_wrdata,
  input  logic                          ar_ac,
  input  logic [DATA_W-1:0]             ar_rddata,
  output logic [ID_W-1:0]               owner_id,
  output logic                          busy,
  output logic                          proto_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] c_rt_id      = ID_W'(RT_ID);
  localparam logic [ID_W-1:0] c_rr_reset   = ID_W'(NUM_CLIENTS - 1);
  localparam logic [7:0]      c_burst_last = 8'(MAX_BURST - 1);
  localparam logic [7:0]      c_beat_sat   = 8'd255;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_owner, w_owner_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [7:0]        r_beat_cnt, w_beat_nxt;
  logic              r_proto_err, w_proto_nxt;

  logic [ADDR_W-1:0] w_addr_arr   [NUM_CLIENTS];
  logic [DATA_W-1:0] w_wrdata_arr [NUM_CLIENTS];
  logic [BE_W-1:0]   w_be_arr     [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] w_req;
  logic                   w_sel_valid;
  logic                   w_sel_rt;
  logic [ID_W-1:0]        w_sel_id;
  logic                   w_own_rd, w_own_wr, w_own_req;
  logic                   w_owner_is_rt;
  logic                   w_release;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
    assign w_addr_arr[gi]   = cli_addr[gi*ADDR_W +: ADDR_W];
    assign w_wrdata_arr[gi] = cli_wrdata[gi*DATA_W +: DATA_W];
    assign w_be_arr[gi]     = cli_be[gi*BE_W +: BE_W];
  end

  assign w_req = cli_rd | cli_wr;

  // RT wins outright; otherwise the nearest non-RT requester after rr_ptr.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rt    = 1'b0;
    w_sel_id    = '0;
    if (w_req[RT_ID]) begin
      w_sel_valid = 1'b1;
      w_sel_rt    = 1'b1;
      w_sel_id    = c_rt_id;
    end else if (!rt_window) begin
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
        if (!w_sel_valid && (((int'(r_rr_ptr) + k) % NUM_CLIENTS) != RT_ID) &&
            w_req[(int'(r_rr_ptr) + k) % NUM_CLIENTS]) begin
          w_sel_valid = 1'b1;
          w_sel_id    = ID_W'((int'(r_rr_ptr) + k) % NUM_CLIENTS);
        end
      end
    end
  end

  assign w_own_rd      = cli_rd[r_owner];
  assign w_own_wr      = cli_wr[r_owner];
  assign w_own_req     = w_own_rd | w_own_wr;
  assign w_owner_is_rt = (r_owner == c_rt_id);
  // Non-RT grants end at a word boundary on the burst limit or an RT window.
  assign w_release     = !w_own_req ||
                         (!w_owner_is_rt && ar_ac &&
                          ((r_beat_cnt == c_burst_last) || rt_window));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= c_rr_reset;
      r_beat_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_proto_err <= w_proto_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_proto_nxt = r_proto_err;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_sel_id;
          w_beat_nxt  = '0;
          if (!w_sel_rt) begin
            w_rr_nxt = w_sel_id;
          end
        end
      end
      ST_OWN: begin
        if (ar_ac && (r_beat_cnt != c_beat_sat)) begin
          w_beat_nxt = r_beat_cnt + 8'd1;
        end
        if (w_own_rd && w_own_wr) begin
          w_proto_nxt = 1'b1;
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ar_addr   = '0;
    ar_be     = '1;
    ar_wrdata = '0;
    ar_read   = 1'b0;
    ar_write  = 1'b0;
    cli_wait  = '1;
    cli_ac    = '0;
    if (r_state == ST_OWN) begin
      ar_addr   = w_addr_arr[r_owner];
      ar_be     = w_be_arr[r_owner];
      ar_wrdata = w_wrdata_arr[r_owner];
      // A simultaneous rd+wr is a protocol error; only the write goes out.
      ar_write  = w_own_wr;
      ar_read   = w_own_rd & ~w_own_wr;
      cli_wait  = ~(NUM_CLIENTS'(1) << r_owner);
      cli_ac    = ar_ac ? (NUM_CLIENTS'(1) << r_owner) : '0;
    end
  end

  assign cli_rddata = ar_rddata;
  assign owner_id   = r_owner;
  assign busy       = (r_state == ST_OWN);
  assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_client_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_client_arbiter;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  localparam int RT = 0;
  localparam int MB = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic            rt_window;
  logic [N-1:0]    cli_rd, cli_wr;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wrdata;
  logic [N*BW-1:0] cli_be;
  logic [N-1:0]    cli_ac, cli_wait;
  logic [DW-1:0]   cli_rddata;
  logic [AW-1:0]   ar_addr;
  logic [BW-1:0]   ar_be;
  logic            ar_read, ar_write;
  logic [DW-1:0]   ar_wrdata;
  logic            ar_ac;
  logic [DW-1:0]   ar_rddata;
  logic [IW-1:0]   owner_id;
  logic            busy, proto_err;

  sdram_client_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RT_ID(RT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .rt_window(rt_window),
    .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_addr(cli_addr),
    .cli_wrdata(cli_wrdata), .cli_be(cli_be),
    .cli_ac(cli_ac), .cli_wait(cli_wait), .cli_rddata(cli_rddata),
    .ar_addr(ar_addr), .ar_be(ar_be), .ar_read(ar_read), .ar_write(ar_write),
    .ar_wrdata(ar_wrdata), .ar_ac(ar_ac), .ar_rddata(ar_rddata),
    .owner_id(owner_id), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, the round-robin pointer, words so far.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_rr    = N - 1;
  int m_beats = 0;
  bit m_err   = 1'b0;

  int checks = 0;
  int errors = 0;
  int ac_cnt [N];
  int grants [$];
  bit prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      cli_addr[i*AW +: AW] = AW'($urandom);
      cli_be[i*BW +: BW]   = BW'($urandom);
      for (int j = 0; j < DW / 32; j++) cli_wrdata[i*DW + j*32 +: 32] = $urandom;
    end
    for (int j = 0; j < DW / 32; j++) ar_rddata[j*32 +: 32] = $urandom;
  endtask

  task automatic clear_inputs();
    rt_window = 1'b0;
    cli_rd    = '0;
    cli_wr    = '0;
    ar_ac     = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic tick();
    int o, best, bestd, d;
    logic rd, wr, rel;
    logic [N-1:0]  ereq, e_wait, e_ac;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    logic e_rd, e_wr;
    #1;
    ereq = cli_rd | cli_wr;
    o  = m_owner;
    rd = cli_rd[o];
    wr = cli_wr[o];
    if (m_busy) begin
      e_addr = cli_addr[o*AW +: AW];
      e_be   = cli_be[o*BW +: BW];
      e_wd   = cli_wrdata[o*DW +: DW];
      e_wr   = wr;
      e_rd   = rd & ~wr;
      e_wait = '1; e_wait[o] = 1'b0;
      e_ac   = '0; e_ac[o]   = ar_ac;
    end else begin
      e_addr = '0; e_be = '1; e_wd = '0; e_wr = 1'b0; e_rd = 1'b0;
      e_wait = '1; e_ac = '0;
    end
    chk("busy", 128'(busy), 128'(m_busy));
    if (m_busy) chk("owner_id", 128'(owner_id), 128'(o));
    chk("proto_err", 128'(proto_err), 128'(m_err));
    chk("ar_addr", 128'(ar_addr), 128'(e_addr));
    chk("ar_be", 128'(ar_be), 128'(e_be));
    chk("ar_wrdata", ar_wrdata, e_wd);
    chk("ar_read", 128'(ar_read), 128'(e_rd));
    chk("ar_write", 128'(ar_write), 128'(e_wr));
    chk("cli_wait", 128'(cli_wait), 128'(e_wait));
    chk("cli_ac", 128'(cli_ac), 128'(e_ac));
    chk("cli_rddata", cli_rddata, ar_rddata);

    for (int i = 0; i < N; i++) ac_cnt[i] += int'(cli_ac[i]);
    if (busy && !prev_busy) grants.push_back(int'(owner_id));
    prev_busy = busy;

    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_rr = N - 1; m_beats = 0; m_err = 1'b0;
    end else if (m_busy) begin
      rel = !(rd || wr) || (o != RT && ar_ac && (m_beats == MB - 1 || rt_window));
      if (rd && wr) m_err = 1'b1;
      if (ar_ac && m_beats < 255) m_beats++;
      if (rel) m_busy = 1'b0;
    end else if (ereq[RT]) begin
      m_busy = 1'b1; m_owner = RT; m_beats = 0;
    end else if (!rt_window) begin
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_rr - 1 + 2 * N) % N;
        if (i != RT && ereq[i] && d < bestd) begin best = i; bestd = d; end
      end
      if (best >= 0) begin
        m_busy = 1'b1; m_owner = best; m_beats = 0; m_rr = best;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    randomize_data();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) ac_cnt[i] = 0;
    grants.delete();
  endtask

  task automatic chk_grants(input string tag, input int n, input int g0, input int g1,
                            input int g2, input int g3);
    int exp [4];
    exp = '{g0, g1, g2, g3};
    chk({tag, "_count"}, 128'(grants.size()), 128'(n));
    for (int i = 0; i < n && i < grants.size(); i++)
      chk({tag, "_order"}, 128'(grants[i]), 128'(exp[i]));
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++) begin
      if (!(cli_rd[i] || cli_wr[i])) begin
        if ($urandom_range(0, (i == RT) ? 9 : 3) == 0) begin
          if ($urandom_range(0, 49) == 0) begin
            cli_rd[i] = 1'b1; cli_wr[i] = 1'b1;
          end else if ($urandom_range(0, 1) == 1) cli_rd[i] = 1'b1;
          else cli_wr[i] = 1'b1;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        cli_rd[i] = 1'b0; cli_wr[i] = 1'b0;
      end
    end
    if ($urandom_range(0, 19) == 0) rt_window = ~rt_window;
    ar_ac = 1'($urandom_range(0, 1));
    reset = ($urandom_range(0, 399) == 0);
    randomize_data();
  endtask

  initial begin
    for (int i = 0; i < N; i++) ac_cnt[i] = 0;
    clear_inputs();
    randomize_data();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset values
    do_reset();
    ar_ac = 1'b1;
    #1;
    chk("rst_cli_wait", 128'(cli_wait), 128'({N{1'b1}}));
    chk("rst_cli_ac", 128'(cli_ac), 128'(0));
    chk("rst_ar_read", 128'(ar_read), 128'(0));
    chk("rst_ar_write", 128'(ar_write), 128'(0));
    chk("rst_ar_be", 128'(ar_be), 128'({BW{1'b1}}));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_owner_id", 128'(owner_id), 128'(0));
    chk("rst_proto_err", 128'(proto_err), 128'(0));

    // Client 2 reads three words acked at cycles 4/6/8
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      cli_rd[2] = (c <= 8);
      ar_ac     = (c == 4 || c == 6 || c == 8);
      tick();
    end
    chk("c2_ack_pulses", 128'(ac_cnt[2]), 128'(3));
    chk_grants("c2_grants", 1, 2, 0, 0, 0);
    chk("c2_idle_after", 128'(busy), 128'(0));

    // Three writers hold requests; burst limit rotates the grant
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      cli_wr[1] = (c <= 19); cli_wr[2] = (c <= 19); cli_wr[3] = (c <= 19);
      ar_ac = 1'b1;
      tick();
    end
    chk_grants("rr_grants", 4, 1, 2, 3, 1);
    chk("rr_ac1", 128'(ac_cnt[1]), 128'(8));
    chk("rr_ac3", 128'(ac_cnt[3]), 128'(4));

    // RT window preempts client 3 at its next word boundary
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      rt_window = (c >= 2 && c <= 14);
      cli_rd[0] = (c >= 2 && c <= 10);
      cli_wr[3] = (c <= 17);
      ar_ac     = (c == 1 || c == 3 || (c >= 5 && c <= 10));
      tick();
    end
    chk_grants("pre_grants", 3, 3, 0, 3, 0);
    chk("pre_rt_acks", 128'(ac_cnt[0]), 128'(6));

    // RT beats a simultaneous non-RT request without moving rr_ptr
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      cli_rd[0] = (c <= 2) || (c >= 10 && c <= 12);
      cli_wr[1] = (c <= 6) || (c >= 10 && c <= 15);
      cli_wr[3] = (c >= 10 && c <= 15);
      ar_ac     = (c == 2 || c == 5 || c == 6 || c == 12);
      tick();
    end
    chk_grants("prio_grants", 4, 0, 1, 0, 3);

    // Simultaneous rd and wr from the owner
    do_reset();
    cli_be[2*BW +: BW] = 16'h00FF;
    for (int c = 0; c <= 5; c++) begin
      cli_rd[2] = 1'b1; cli_wr[2] = 1'b1;
      tick();
    end
    #1;
    chk("pe_ar_write", 128'(ar_write), 128'(1));
    chk("pe_ar_read", 128'(ar_read), 128'(0));
    chk("pe_ar_be", 128'(ar_be), 128'(16'h00FF));
    chk("pe_flag", 128'(proto_err), 128'(1));
    cli_rd[2] = 1'b0; cli_wr[2] = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    #1;
    chk("pe_sticky", 128'(proto_err), 128'(1));
    do_reset();
    #1;
    chk("pe_cleared", 128'(proto_err), 128'(0));

    // Reset while a non-RT client owns the bus
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      cli_wr[1] = 1'b1;
      reset     = (c == 2);
      tick();
    end
    reset     = 1'b0;
    cli_rd[0] = 1'b1;
    #1;
    chk("rso_busy", 128'(busy), 128'(0));
    chk("rso_strobes", 128'({ar_read, ar_write}), 128'(0));
    chk("rso_wait", 128'(cli_wait), 128'({N{1'b1}}));
    grants.delete();
    for (int c = 0; c < 3; c++) tick();
    chk("rso_first", 128'(grants.size() > 0 ? grants[0] : -1), 128'(0));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rand_step();
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_client_arbiter.md
# sdram_client_arbiter

Parametrised N-client arbiter between the frame-engine clients (line buffer, background, score, note, PCM, init loaders) and the single-port SDRAM controller. One client is the real-time (RT) line-buffer client. It has absolute priority and exclusive use of the bus inside a video-timing window. The other clients share the bus round-robin, with burst locking and a per-grant word limit. It replaces hard-coded per-phase muxing with a registered grant state machine.

## Interface
Parameters:
- NUM_CLIENTS, 4, number of clients (2..8)
- ADDR_W, 22, SDRAM word address width
- DATA_W, 128, data width; BE_W = DATA_W/8 (derived)
- RT_ID, 0, index of the real-time client
- MAX_BURST, 16, max words acknowledged per non-RT grant (1..255); RT is unlimited

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rt_window  in  1  high = RT-only period (for example DrawX 765..799 plus line fetch)
- cli_rd  in  NUM_CLIENTS  per-client read request
- cli_wr  in  NUM_CLIENTS  per-client write request
- cli_addr  in  NUM_CLIENTS*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
- cli_wrdata  in  NUM_CLIENTS*DATA_W  packed write data
- cli_be  in  NUM_CLIENTS*BE_W  packed byte enables
- cli_ac  out  NUM_CLIENTS  per-word acknowledge; only the owner's bit can be 1
- cli_wait  out  NUM_CLIENTS  1 = client does not own the bus
- cli_rddata  out  DATA_W  ar_rddata broadcast, ungated
- ar_addr  out  ADDR_W  address to the controller
- ar_be  out  BE_W  byte enables to the controller
- ar_read  out  1  read strobe to the controller
- ar_write  out  1  write strobe to the controller
- ar_wrdata  out  DATA_W  write data to the controller
- ar_ac  in  1  controller word acknowledge
- ar_rddata  in  DATA_W  controller read data
- owner_id  out  $clog2(NUM_CLIENTS)  current owner; valid when busy = 1
- busy  out  1  state is OWN
- proto_err  out  1  sticky flag: owner asserted rd and wr together

## Operation
- Registered state: `state` (IDLE/OWN), `owner`, `rr_ptr`, `beat_cnt`, `proto_err`.
- IDLE:
  - All ar_* strobes are 0, ar_addr/ar_wrdata are 0, ar_be is all-ones, all cli_wait are 1, all cli_ac are 0.
  - A client is requesting when cli_rd[i] | cli_wr[i].
  - Selection:
    - RT_ID requesting → grant RT_ID.
    - Else, if rt_window = 1 → no grant.
    - Else, grant the first requesting non-RT client searching upward from rr_ptr+1, with wrap-around, skipping RT_ID.
  - On a grant: state goes to OWN, owner = selected client, beat_cnt = 0. For a non-RT grant, rr_ptr = owner.
- OWN:
  - ar_addr, ar_be, ar_wrdata, ar_read and ar_write are driven combinationally from the owner's signals.
  - cli_wait[owner] = 0 and cli_ac[owner] = ar_ac.
  - If the owner asserts rd and wr together: forward the write only (ar_read = 0) and set proto_err.
  - Each ar_ac increments beat_cnt, saturating at 255.
- Release to IDLE at the clock edge after any of these:
  - The owner deasserts both rd and wr (a client must hold its request until ar_ac; dropping early still releases the bus).
  - For a non-RT owner, ar_ac = 1 while beat_cnt == MAX_BURST-1 (burst limit reached).
  - For a non-RT owner, ar_ac = 1 while rt_window = 1 (preemption at a word boundary).
  - ar_ac = 1 on a word that is not the last never releases unless one of the conditions above holds.
- Simultaneous events:
  - Request drop and ar_ac in the same cycle → the ack is delivered to the owner, then release.
  - RT and non-RT requesting in the same IDLE cycle → RT wins and rr_ptr is unchanged.
- Reset:
  - state = IDLE, owner = 0, rr_ptr = NUM_CLIENTS-1 (so the first non-RT search starts at client 0), beat_cnt = 0, proto_err = 0.
  - Reset during OWN forces every ar_* strobe to 0 from the next cycle. Any in-flight controller transaction is abandoned; the controller must also be reset.

## Timing
- Grant latency: a request sampled in IDLE at edge t gives OWN in cycle t+1, with cli_wait low and ar_* valid in that same cycle.
- Between owners there is exactly one IDLE cycle, with strobes low.
- cli_ac is combinational from ar_ac (zero latency). cli_rddata is valid in the ar_ac cycle.
- All outputs are glitch-free relative to clk; there are no combinational loops from cli_* to cli_wait.
- Reset values: cli_wait all 1, cli_ac 0, ar_read/ar_write 0, ar_be all-ones, busy 0, owner_id 0, proto_err 0.

## Test plan
- Reset, then client 2 reads 3 words, acked at cycles 4/6/8 → owner_id = 2 from cycle 1, three cli_ac[2] pulses, IDLE after client 2 drops its request.
- Clients 1, 2 and 3 hold write requests continuously, MAX_BURST = 4 → grants go 1, 2, 3, 1, each ending after exactly 4 acks, with one IDLE cycle between grants.
- Client 3 is mid-burst and rt_window rises with RT requesting → client 3 released on its next ar_ac; RT owns the bus 2 cycles after that ack; client 3 is regranted only after rt_window falls and RT idles.
- RT and client 1 both request in IDLE with rt_window = 0 → RT granted and rr_ptr unchanged; client 1 is granted immediately after RT releases.
- Owner asserts rd and wr together with be = 16'h00FF → ar_write = 1, ar_read = 0, ar_be = 16'h00FF, proto_err = 1 and held until reset.
- Reset asserted while a non-RT client owns the bus → next cycle busy = 0, strobes 0, cli_wait all 1; after release, a fresh request from client 0 is granted first.
